wfifo_wr_arbiter: RTL and testbench
===================================

// Module: wfifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of the async FIFO between N producers in the wclk domain.
//  Grants one requester at a time for a whole burst (until its last beat), gates writes with wfull,
//  and drives winc/wdata into the write-pointer block and FIFO storage.
//  Sits directly upstream of the write-pointer/full-flag logic; the read side is unaffected.
// PARAMETERS
//  N          4   number of requesters (2..8)
//  DW         8   data width per beat
//  MAX_BURST  16  beats after which a grant is force-released (fairness bound), 1..255
// PORTS
//  wclk       in   1      write-domain clock
//  wrst_n     in   1      asynchronous active-low reset (async assert; all flops clear)
//  req        in   N      per-requester valid
//  req_data   in   N*DW   packed beat data, requester i at [i*DW +: DW]
//  req_last   in   N      final beat of requester's burst
//  ready      out  N      per-requester accept; beat transfers when req[i] & ready[i]
//  wfull      in   1      registered full flag from write-pointer block
//  winc       out  1      FIFO write enable (one beat per asserted cycle)
//  wdata      out  DW     FIFO write data
//  gnt_id     out  log2N  index of current owner (valid while busy)
//  busy       out  1      a grant is held
// BEHAVIOUR
//  - Reset values: ready=0, winc=0, wdata=0, gnt_id=0, busy=0, state=IDLE, rr pointer=N-1 (requester 0 wins first).
//  - FSM IDLE: if |req, pick first set req[] searching from rr_ptr+1 upward with wrap; register gnt_id, busy=1,
//    beat count=0, go BURST next edge. Arbitration latency 1 cycle; no beat accepted in IDLE.
//  - FSM BURST: ready[gnt_id] = ~wfull; all other ready bits 0 (combinational from state and wfull).
//    winc = req[gnt_id] & ~wfull; wdata = req_data slice of gnt_id (combinational; 0 when winc=0).
//  - On a transfer: beat count++. If req_last[gnt_id] OR count reaches MAX_BURST-1: rr_ptr<=gnt_id,
//    busy<=0, go IDLE. New arbitration next cycle, so min 1 idle cycle between grants.
//  - Owner deasserting req mid-burst: grant held, no write, no release (lock until last/MAX_BURST).
//  - wfull=1: no winc, ready=0, state/count frozen; resumes same cycle wfull drops.
//  - wfull sampled as given; never write when wfull=1 (no overflow possible from this block).
//  - Non-owner req changes during BURST: ignored, no effect on current grant.
//  - Single requester: regrants itself after 1 idle cycle; rr wrap N-1 -> 0 exact.
//  - Reset mid-burst: immediate clear to reset values; partial burst abandoned (FIFO side owns recovery).
// CONFIGURATION
//  WARB_STATS_EN defined: adds output stat_beats [N*16-1:0], per-requester 16-bit beat counters,
//    +1 on each transfer of that requester, saturate at 16'hFFFF, cleared only by wrst_n.
//  WARB_STATS_EN undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package wfifo_pkg: FSM state enum {IDLE, BURST}, helper constant for log2(N) width.
//  - One sub-module: wfifo_rr_pick (combinational round-robin priority search: req, rr_ptr -> idx, found).
//  - Top holds FSM, beat counter, data mux and optional stats.
// TESTING
//  1 Reset: wrst_n low with req=4'hF -> ready=0, winc=0, busy=0; release -> gnt_id=0 busy=1 after 1 edge.
//  2 Fairness: req=4'hF, every beat last -> grants 0,1,2,3,0 with one IDLE cycle between; winc pulses 4 of 8 cycles.
//  3 Full stall: owner 2 mid-burst, wfull=1 for 5 cycles -> winc=0, ready=0, gnt_id stays 2; wfull=0 -> beat written same cycle.
//  4 MAX_BURST=16, req_last never set -> exactly 16 winc beats then release; next requester granted.
//  5 Owner gaps: req[1] drops 3 cycles mid-burst, req[0] high -> no grant change, no winc, resumes with req[1].
//  6 WARB_STATS_EN: 70000 beats from requester 3 -> stat_beats[63:48]=16'hFFFF, others 0; mid-burst reset clears all.

Source files
------------

// File: rtl/wfifo_pkg.sv
// ---------------------------------------------------------------------------
// wfifo_pkg
// Shared definitions for the async-FIFO write-side arbiter:
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   CNT_W       : width of the per-burst beat counter (MAX_BURST <= 255)
//   idx_w()     : width of a requester index for N requesters (minimum 1)
// ---------------------------------------------------------------------------
package wfifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wfifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wfifo_wr_arbiter_if
// Bundles the producer handshake and the FIFO write port of the arbiter.
//   req/req_data/req_last : N producers (data of requester i at [i*DW +: DW])
//   ready                 : per-requester accept
//   wfull                 : registered full flag from the write-pointer block
//   winc/wdata            : FIFO write enable and data
//   gnt_id/busy           : current owner and grant-held flag
// Modports: slave = arbiter side, master = producers / FIFO side.
// ---------------------------------------------------------------------------
interface wfifo_wr_arbiter_if
    import wfifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = idx_w(N);

    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ready;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   gnt_id;
    logic            busy;

    modport slave (
        input  req, req_data, req_last, wfull,
        output ready, winc, wdata, gnt_id, busy
    );

    modport master (
        output req, req_data, req_last, wfull,
        input  ready, winc, wdata, gnt_id, busy
    );

endinterface

// File: rtl/wfifo_rr_pick.sv
// ---------------------------------------------------------------------------
// wfifo_rr_pick
// Combinational round-robin search: returns the first set bit of i_req,
// scanning upward from i_rr_ptr+1 and wrapping past N-1 to 0.
//   i_req    : request vector
//   i_rr_ptr : index of the last owner (lowest priority this round)
//   o_idx    : chosen requester (0 when none)
//   o_found  : at least one request present
// ---------------------------------------------------------------------------
module wfifo_rr_pick
    import wfifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    int w_dist;
    int w_best;

    // Each requester's distance behind the pointer; the smallest set one wins.
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_best  = N;
        w_dist  = 0;
        for (int k = 0; k < N; k++) begin
            w_dist = (k + 2 * N - int'(i_rr_ptr) - 1) % N;
            if (i_req[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IW'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wfifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// wfifo_wr_arbiter
// Round-robin arbiter sharing the async FIFO write port between N producers
// in the wclk domain. A grant is held for a whole burst (until the owner's
// last beat or MAX_BURST beats), and writes are gated by wfull.
//   wclk, wrst_n : write clock, asynchronous active-low reset
//   bus (slave)  : producer handshake, wfull in, winc/wdata/gnt_id/busy out
//   stat_beats   : per-requester 16-bit saturating beat counters
//                  (present only when WARB_STATS_EN is defined)
// ---------------------------------------------------------------------------
module wfifo_wr_arbiter
    import wfifo_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                wclk,
    input  logic                wrst_n,
    wfifo_wr_arbiter_if.slave   bus
`ifdef WARB_STATS_EN
    ,
    output logic [N*16-1:0]     stat_beats
`endif
);

    localparam int IW = idx_w(N);

    arb_state_e     r_state,  w_state_nxt;
    logic [IW-1:0]  r_gnt_id, w_gnt_nxt;
    logic [IW-1:0]  r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;

    logic [IW-1:0]  w_pick_idx;
    logic           w_pick_found;
    logic [N-1:0]   w_owner_sel;
    logic [DW-1:0]  w_owner_data;
    logic           w_burst;
    logic           w_xfer;
    logic           w_release;

    wfifo_rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    // One-hot owner select and owner data slice.
    always_comb begin
        w_owner_sel  = '0;
        w_owner_data = '0;
        for (int k = 0; k < N; k++) begin
            if (IW'(k) == r_gnt_id) begin
                w_owner_sel[k] = 1'b1;
                w_owner_data   = bus.req_data[k*DW +: DW];
            end
        end
    end

    assign w_burst   = (r_state == BURST);
    assign w_xfer    = w_burst & (|(bus.req & w_owner_sel)) & ~bus.wfull;
    // r_cnt counts beats already taken, so MAX_BURST-1 marks the final one.
    assign w_release = w_xfer & ((|(bus.req_last & w_owner_sel)) |
                                 (r_cnt == CNT_W'(MAX_BURST - 1)));

    assign bus.ready  = (w_burst & ~bus.wfull) ? w_owner_sel : '0;
    assign bus.winc   = w_xfer;
    assign bus.wdata  = w_xfer ? w_owner_data : '0;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = w_burst;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = BURST;
                    w_gnt_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = r_gnt_id;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state  <= IDLE;
            r_gnt_id <= '0;
            r_rr_ptr <= IW'(N - 1);
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

`ifdef WARB_STATS_EN
    logic [15:0] r_stat [N];

    // NOTE: the counter array is reset explicitly; it must read zero after
    // wrst_n, so it is built from flops rather than a RAM.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int k = 0; k < N; k++) r_stat[k] <= '0;
        end else if (w_xfer) begin
            for (int k = 0; k < N; k++) begin
                if (w_owner_sel[k] && (r_stat[k] != 16'hFFFF)) begin
                    r_stat[k] <= r_stat[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int k = 0; k < N; k++) stat_beats[k*16 +: 16] = r_stat[k];
    end
`endif

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wfifo_wr_arbiter
// Scoreboard bench: the driver applies one cycle of stimulus, a burst-level
// model predicts that cycle's outputs and pushes them; a negedge monitor pops
// and compares. Beats written to the FIFO are checked against a second queue.
// Compile with WARB_STATS_EN defined to also exercise the beat counters.
// ---------------------------------------------------------------------------
module tb_wfifo_wr_arbiter;
    import wfifo_pkg::*;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 16;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    wfifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

`ifdef WARB_STATS_EN
    logic [N*16-1:0] stat_beats;
`endif

    wfifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
`ifdef WARB_STATS_EN
        ,
        .stat_beats (stat_beats)
`endif
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit            busy;
        int            gnt;
        logic [N-1:0]  ready;
        bit            winc;
        logic [DW-1:0] wdata;
    } cyc_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } beat_t;

    cyc_t  exp_cyc[$];
    beat_t exp_beat[$];
    cyc_t  mon_e;
    beat_t mon_b;

    int checks    = 0;
    int errors    = 0;
    bit mon_en    = 1'b0;
    int winc_seen = 0;

    // Model: current owner (-1 = nobody), beats in this burst, last owner.
    int m_owner = -1;
    int m_beats = 0;
    int m_prev  = N - 1;
    int m_stat [N];

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_prev  = N - 1;
        for (int k = 0; k < N; k++) m_stat[k] = 0;
        exp_cyc.delete();
        exp_beat.delete();
    endtask

    // Apply one cycle of inputs, predict that cycle, advance to posedge+1.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] last,
                         input bit wfull);
        cyc_t            e;
        logic [N*DW-1:0] data;
        for (int k = 0; k < N; k++) data[k*DW +: DW] = DW'($urandom);
        bus.req      = req;
        bus.req_last = last;
        bus.req_data = data;
        bus.wfull    = wfull;

        e.busy  = (m_owner >= 0);
        e.gnt   = 0;
        e.ready = '0;
        e.winc  = 1'b0;
        e.wdata = '0;
        if (m_owner < 0) begin
            for (int s = 1; s <= N; s++) begin
                int c;
                c = (m_prev + s) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else begin
            e.gnt = m_owner;
            if (!wfull) e.ready[m_owner] = 1'b1;
            if (req[m_owner] && !wfull) begin
                e.winc  = 1'b1;
                e.wdata = data[m_owner*DW +: DW];
                exp_beat.push_back('{m_owner, e.wdata});
                m_beats++;
                if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
                if (last[m_owner] || m_beats == MAX_BURST) begin
                    m_prev  = m_owner;
                    m_owner = -1;
                end
            end
        end
        exp_cyc.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.ready,  0);
        check({tag, "_winc"},  bus.winc,   0);
        check({tag, "_busy"},  bus.busy,   0);
        check({tag, "_gnt"},   bus.gnt_id, 0);
        check({tag, "_wdata"}, bus.wdata,  0);
`ifdef WARB_STATS_EN
        check({tag, "_stats"}, stat_beats, 0);
`endif
    endtask

`ifdef WARB_STATS_EN
    task automatic check_stats(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_stat%0d", tag, k), stat_beats[k*16 +: 16], m_stat[k]);
    endtask
`endif

    // Reset mid-burst: assert away from the clock edge, check the async clear.
    task automatic reset_mid_burst(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (m_owner >= 0 && m_beats > 0) break;
            drive(4'hF, 4'h0, 1'b0);
        end
        check({tag, "_was_busy"}, bus.busy, 1);
        mon_en = 1'b0;
        #2;
        wrst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    always @(negedge wclk) begin
        if (mon_en) begin
            if (exp_cyc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cyc_queue: no prediction for sampled cycle at %0t", $time);
            end else begin
                mon_e = exp_cyc.pop_front();
                check("busy",  bus.busy,  mon_e.busy);
                check("winc",  bus.winc,  mon_e.winc);
                check("ready", bus.ready, mon_e.ready);
                check("wdata", bus.wdata, mon_e.wdata);
                if (mon_e.busy) check("gnt_id", bus.gnt_id, mon_e.gnt);
            end
            if (bus.winc === 1'b1) begin
                winc_seen++;
                if (exp_beat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_queue: unexpected write data %0h at %0t", bus.wdata, $time);
                end else begin
                    mon_b = exp_beat.pop_front();
                    check("beat_id",   bus.gnt_id, mon_b.id);
                    check("beat_data", bus.wdata,  mon_b.data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;
        wrst_n       = 1'b0;

        // Reset held with all requests pending.
        bus.req = 4'hF;
        repeat (3) @(posedge wclk);
        #1;
        check_reset_outputs("rst");
        wrst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        drive(4'hF, 4'h0, 1'b0);
        check("rst_first_busy", bus.busy,   1);
        check("rst_first_gnt",  bus.gnt_id, 0);

        // Fairness: single-beat bursts from everyone.
        s = winc_seen;
        repeat (8) drive(4'hF, 4'hF, 1'b0);
        check("fair_winc_count", winc_seen - s, 4);
        drive(4'hF, 4'hF, 1'b0);

        // Full stall on owner 2.
        drive(4'b0100, 4'h0, 1'b0);
        drive(4'b0100, 4'h0, 1'b0);
        drive(4'b0100, 4'h0, 1'b0);
        s = winc_seen;
        repeat (5) drive(4'b0100, 4'h0, 1'b1);
        check("stall_winc_count", winc_seen - s, 0);
        check("stall_gnt", bus.gnt_id, 2);
        drive(4'b0100, 4'h0, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0);

        // MAX_BURST release without req_last.
        drive(4'b0011, 4'h0, 1'b0);
        s = winc_seen;
        repeat (17) drive(4'b0011, 4'h0, 1'b0);
        check("maxburst_winc_count", winc_seen - s, MAX_BURST);

        // Owner gaps: requester 1 drops for 3 cycles while 0 waits.
        drive(4'b0011, 4'h0, 1'b0);
        s = winc_seen;
        repeat (3) drive(4'b0001, 4'h0, 1'b0);
        check("gap_winc_count", winc_seen - s, 0);
        check("gap_gnt", bus.gnt_id, 1);
        drive(4'b0011, 4'b0010, 1'b0);

        // Random traffic: short bursts, then long bursts hitting MAX_BURST.
        repeat (1500)
            drive(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 4) == 0));
        repeat (1500)
            drive(N'($urandom | $urandom),
                  N'($urandom & $urandom & $urandom & $urandom & $urandom),
                  ($urandom_range(0, 4) == 0));
`ifdef WARB_STATS_EN
        check_stats("rand");
`endif
        reset_mid_burst("midrst");

`ifdef WARB_STATS_EN
        // Saturate requester 3's counter.
        repeat (69700) drive(4'b1000, 4'h0, 1'b0);
        check_stats("sat");
        check("sat_stat3_ffff", stat_beats[63:48], 16'hFFFF);
        reset_mid_burst("satrst");
`endif

        drive(4'h0, 4'h0, 1'b0);
        mon_en = 1'b0;
        check("drain_cyc",  exp_cyc.size(),  0);
        check("drain_beat", exp_beat.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
